// File: rtl/eth_pkg.sv
// Shared Ethernet/IP transmit and receive constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

    localparam logic [7:0]  IPHL        = 8'h45;
    localparam logic [7:0]  TOS         = 8'h00;
    localparam logic [15:0] FLAG_OFFSET = 16'h0000;
    localparam logic [7:0]  IP_UDP_TYPE = 8'h11;
    localparam int          IP_HDR_LEN  = 20;

    typedef enum logic [1:0] {
        IPTX_IDLE,
        IPTX_CALC,
        IPTX_FOLD,
        IPTX_SEND
    } ip_tx_state_t;

    // Request fields held stable for the whole header.
    typedef struct packed {
        logic [15:0] len;
        logic [15:0] id;
        logic [31:0] s_addr;
        logic [31:0] d_addr;
    } ip_hdr_t;

endpackage

// File: rtl/ip_checksum_fold.sv
// One's-complement fold of a 32-bit partial sum to a 16-bit inverted checksum.
// Latency: combinational.
// Backpressure: none.
module ip_checksum_fold (
    input  logic [31:0] sum,
    output logic [15:0] csum
);

    logic [16:0] fold1;
    logic [15:0] fold2;

    // Two end-around carries are enough for a 32-bit sum of 16-bit words.
    assign fold1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    assign fold2 = fold1[15:0] + {15'h0000, fold1[16]};
    assign csum  = ~fold2;

endmodule

// File: rtl/ip_header_tx.sv
// Byte-serial IPv4 header generator for the UDP transmit path.
// Latency: first byte 6 cycles after accept; 20 bytes, done pulse the cycle after the last transfer.
// Backpressure: data_valid/data_ready; data_out held stable while stalled, start_ready only in IDLE.
module ip_header_tx
    import eth_pkg::*;
#(
    parameter logic [7:0]  IP_TTL     = 8'hFF,
    parameter logic [15:0] IP_ID_INIT = 16'h0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        start_ready,
    input  logic [15:0] payload_len,
    input  logic [31:0] ip_s_addr,
    input  logic [31:0] ip_d_addr,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        ip_header_done,
    output logic        ip_len_err
);

    localparam logic [4:0]  LAST_IDX    = 5'(IP_HDR_LEN - 1);
    localparam logic [15:0] MAX_PAYLOAD = 16'hFFFF - 16'(IP_HDR_LEN);

    ip_tx_state_t state, state_nxt;
    ip_hdr_t      hdr;
    logic [1:0]   stage;
    logic [31:0]  sum;
    logic [15:0]  csum_fold;
    logic [15:0]  csum;
    logic [4:0]   idx;
    logic [15:0]  id_cnt;
    logic         len_ok;
    logic         xfer;

    assign start_ready = (state == IPTX_IDLE);
    assign len_ok      = (payload_len <= MAX_PAYLOAD);
    assign xfer        = data_valid && data_ready;

    ip_checksum_fold u_fold (
        .sum  (sum),
        .csum (csum_fold)
    );

    function automatic logic [7:0] hdr_byte(input logic [4:0] i, input ip_hdr_t h,
                                            input logic [15:0] cs);
        hdr_byte = h.d_addr[7:0];
        case (i)
            5'd0:  hdr_byte = IPHL;
            5'd1:  hdr_byte = TOS;
            5'd2:  hdr_byte = h.len[15:8];
            5'd3:  hdr_byte = h.len[7:0];
            5'd4:  hdr_byte = h.id[15:8];
            5'd5:  hdr_byte = h.id[7:0];
            5'd6:  hdr_byte = FLAG_OFFSET[15:8];
            5'd7:  hdr_byte = FLAG_OFFSET[7:0];
            5'd8:  hdr_byte = IP_TTL;
            5'd9:  hdr_byte = IP_UDP_TYPE;
            5'd10: hdr_byte = cs[15:8];
            5'd11: hdr_byte = cs[7:0];
            5'd12: hdr_byte = h.s_addr[31:24];
            5'd13: hdr_byte = h.s_addr[23:16];
            5'd14: hdr_byte = h.s_addr[15:8];
            5'd15: hdr_byte = h.s_addr[7:0];
            5'd16: hdr_byte = h.d_addr[31:24];
            5'd17: hdr_byte = h.d_addr[23:16];
            5'd18: hdr_byte = h.d_addr[15:8];
            default: hdr_byte = h.d_addr[7:0];
        endcase
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IPTX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IPTX_IDLE: if (start && len_ok) state_nxt = IPTX_CALC;
            IPTX_CALC: if (stage == 2'd3) state_nxt = IPTX_FOLD;
            IPTX_FOLD: state_nxt = IPTX_SEND;
            IPTX_SEND: if (xfer && idx == LAST_IDX) state_nxt = IPTX_IDLE;
            default:   state_nxt = IPTX_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr            <= '0;
            stage          <= 2'd0;
            sum            <= 32'h0;
            csum           <= 16'h0;
            idx            <= 5'd0;
            id_cnt         <= IP_ID_INIT;
            data_out       <= 8'h00;
            data_valid     <= 1'b0;
            ip_header_done <= 1'b0;
            ip_len_err     <= 1'b0;
        end else begin
            ip_header_done <= 1'b0;
            ip_len_err     <= 1'b0;
            case (state)
                IPTX_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            hdr.len    <= payload_len + 16'(IP_HDR_LEN);
                            hdr.id     <= id_cnt;
                            hdr.s_addr <= ip_s_addr;
                            hdr.d_addr <= ip_d_addr;
                            sum        <= 32'h0;
                            stage      <= 2'd0;
                        end else begin
                            ip_len_err <= 1'b1;
                        end
                    end
                end
                IPTX_CALC: begin
                    // Checksum field contributes zero to the sum.
                    stage <= stage + 2'd1;
                    case (stage)
                        2'd0: sum <= sum + {16'h0, IPHL, TOS} + {16'h0, hdr.len};
                        2'd1: sum <= sum + {16'h0, hdr.id} + {16'h0, FLAG_OFFSET};
                        2'd2: sum <= sum + {16'h0, IP_TTL, IP_UDP_TYPE}
                                         + {16'h0, hdr.s_addr[31:16]} + {16'h0, hdr.s_addr[15:0]};
                        default: sum <= sum + {16'h0, hdr.d_addr[31:16]}
                                            + {16'h0, hdr.d_addr[15:0]};
                    endcase
                end
                IPTX_FOLD: begin
                    csum       <= csum_fold;
                    idx        <= 5'd0;
                    data_out   <= IPHL;
                    data_valid <= 1'b1;
                end
                IPTX_SEND: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            data_valid     <= 1'b0;
                            data_out       <= 8'h00;
                            ip_header_done <= 1'b1;
                            id_cnt         <= id_cnt + 16'd1;
                        end else begin
                            idx      <= idx + 5'd1;
                            data_out <= hdr_byte(idx + 5'd1, hdr, csum);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_tx.sv
// Directed bench for ip_header_tx with a byte scoreboard and reference checksum.
// Latency: checks first-byte and done offsets from the accept edge.
// Backpressure: optional random data_ready with hold-stability checks.
module tb_ip_header_tx;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        start_ready;
    logic [15:0] payload_len;
    logic [31:0] ip_s_addr;
    logic [31:0] ip_d_addr;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        ip_header_done;
    logic        ip_len_err;

    ip_header_tx dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .start          (start),
        .start_ready    (start_ready),
        .payload_len    (payload_len),
        .ip_s_addr      (ip_s_addr),
        .ip_d_addr      (ip_d_addr),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .ip_header_done (ip_header_done),
        .ip_len_err     (ip_len_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int vld_cnt = 0;
    int nbytes = 0;
    int first_vld = 0;
    int done_cyc = 0;
    int d0 = 0;
    int e0 = 0;
    bit bp_en = 0;
    bit vld_seen = 0;
    bit stall_prev = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] obs[20];

    localparam logic [31:0] SA  = 32'hC0A8000A;
    localparam logic [31:0] DA  = 32'hC0A80001;
    localparam logic [31:0] SA2 = 32'h0A000001;
    localparam logic [31:0] DA2 = 32'h0A0000FE;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference header built word by word with an independent checksum loop.
    function automatic void push_hdr(input logic [31:0] sa, input logic [31:0] da,
                                     input logic [15:0] pl, input logic [15:0] id);
        logic [15:0] w[10];
        logic [31:0] s;
        s = 32'h0;
        w = '{16'h4500, pl + 16'd20, id, 16'h0000, 16'hFF11, 16'h0000,
              sa[31:16], sa[15:0], da[31:16], da[15:0]};
        for (int i = 0; i < 10; i++) s = s + {16'h0, w[i]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        w[5] = ~s[15:0];
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
        end
    endfunction

    // One cycle: sample outputs at negedge, then drive data_ready for the next edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge aclk);
        cyc++;
        if (aresetn) begin
            if (stall_prev) begin
                chk("stall_vld", 32'(data_valid), 1);
                chk("stall_dat", 32'(data_out), 32'(held));
            end
            if (data_valid && !vld_seen) begin
                vld_seen  = 1;
                first_vld = cyc;
            end
            if (data_valid) vld_cnt++;
            if (ip_header_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ip_len_err) err_cnt++;
        end
        data_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (aresetn && data_valid && data_ready) begin
            chk("q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("byte", 32'(data_out), 32'(e));
            end
            if (nbytes < 20) obs[nbytes] = data_out;
            nbytes++;
        end
        stall_prev = aresetn && data_valid && !data_ready;
        held       = data_out;
    endtask

    task automatic req(input logic [31:0] sa, input logic [31:0] da,
                       input logic [15:0] pl, input logic [15:0] id);
        chk("start_ready_pre", 32'(start_ready), 1);
        ip_s_addr   = sa;
        ip_d_addr   = da;
        payload_len = pl;
        start       = 1'b1;
        if (pl <= 16'hFFEB) push_hdr(sa, da, pl, id);
        acc      = cyc;
        vld_seen = 0;
        vld_cnt  = 0;
        nbytes   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) tick();
        chk("done_in_budget", 32'(done_cnt > base), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn     = 1'b0;
        start       = 1'b0;
        payload_len = 16'h0;
        ip_s_addr   = 32'h0;
        ip_d_addr   = 32'h0;
        data_ready  = 1'b1;
        tick();
        tick();
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_done", 32'(ip_header_done), 0);
        chk("rst_len_err", 32'(ip_len_err), 0);
        aresetn = 1'b1;
        tick();

        // Reference header, ready held high.
        req(SA, DA, 16'h05C8, 16'h0000);
        chk("t1_busy", 32'(start_ready), 0);
        wait_done(60);
        chk("t1_first_ofs", first_vld - acc, 6);
        chk("t1_done_ofs", done_cyc - acc, 26);
        chk("t1_vld_cycles", vld_cnt, 20);
        chk("t1_len", {16'h0, obs[2], obs[3]}, 32'h05DC);
        chk("t1_cs", {16'h0, obs[10], obs[11]}, 32'h34B5);
        chk("t1_ready_after", 32'(start_ready), 1);

        // Back-to-back identical request picks up the incremented ID.
        req(SA, DA, 16'h05C8, 16'h0001);
        wait_done(60);
        chk("t2_id", {16'h0, obs[4], obs[5]}, 32'h0001);
        chk("t2_cs", {16'h0, obs[10], obs[11]}, 32'h34B4);

        // Random back-pressure.
        bp_en = 1;
        d0 = done_cnt;
        req(SA2, DA2, 16'h0100, 16'h0002);
        wait_done(600);
        bp_en = 0;
        repeat (10) tick();
        chk("t3_one_done", done_cnt - d0, 1);
        chk("t3_bytes", nbytes, 20);

        // Oversize payload is rejected; the largest legal one is sent.
        e0 = err_cnt;
        req(SA, DA, 16'hFFEC, 16'h0003);
        chk("t4_len_err", 32'(ip_len_err), 1);
        chk("t4_ready", 32'(start_ready), 1);
        tick();
        chk("t4_len_err_pulse", 32'(ip_len_err), 0);
        repeat (8) tick();
        chk("t4_no_valid", vld_cnt, 0);
        chk("t4_err_count", err_cnt - e0, 1);
        req(SA, DA, 16'hFFEB, 16'h0003);
        wait_done(60);
        chk("t4_len_max", {16'h0, obs[2], obs[3]}, 32'hFFFF);
        chk("t4_id_kept", {16'h0, obs[4], obs[5]}, 32'h0003);

        // Request raised during SEND waits for start_ready.
        req(SA, DA, 16'h0040, 16'h0004);
        for (int i = 0; i < 20 && !vld_seen; i++) tick();
        ip_s_addr   = SA2;
        ip_d_addr   = DA2;
        payload_len = 16'h0010;
        start       = 1'b1;
        push_hdr(SA2, DA2, 16'h0010, 16'h0005);
        d0 = done_cnt;
        tick();
        chk("t5_ignored", 32'(start_ready), 0);
        for (int i = 0; i < 60 && !start_ready; i++) tick();
        chk("t5_ready_back", 32'(start_ready), 1);
        chk("t5_a_done", done_cnt - d0, 1);
        acc      = cyc;
        vld_seen = 0;
        vld_cnt  = 0;
        nbytes   = 0;
        tick();
        start = 1'b0;
        wait_done(60);
        chk("t5_b_first_ofs", first_vld - acc, 6);
        chk("t5_b_sa", {obs[12], obs[13], obs[14], obs[15]}, SA2);

        // Reset while byte 7 is on the bus.
        req(SA, DA, 16'h05C8, 16'h0006);
        for (int i = 0; i < 40 && nbytes < 8; i++) tick();
        chk("t6_at_byte7", nbytes, 8);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_vld_low", 32'(data_valid), 0);
        chk("t6_done_low", 32'(ip_header_done), 0);
        chk("t6_ready", 32'(start_ready), 1);
        exp_q.delete();
        stall_prev = 0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        req(SA, DA, 16'h05C8, 16'h0000);
        wait_done(60);
        chk("t6_id_init", {16'h0, obs[4], obs[5]}, 32'h0000);
        chk("t6_cs", {16'h0, obs[10], obs[11]}, 32'h34B5);

        repeat (5) tick();
        chk("q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
